// File: rtl/mdu_pkg.sv
// ============================================================================
//  Module : mdu_pkg
//  Shared encodings, widths and decode helpers for the multiply/divide unit.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_DIVU) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_neg.sv
// ============================================================================
//  Module : mdu_neg
//  Conditional two's-complement negate; passes the input through when i_neg=0.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module mdu_neg #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_neg ? -i_a : i_a;

endmodule

`default_nettype wire

// File: rtl/mdu_32.sv
// ============================================================================
//  Module : mdu_32
//  Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module mdu_32
    import mdu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    state_t             r_state;
    logic [1:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_opb;
    logic               r_sgn_diff;
    logic               r_sgn_a;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_nxt_hi;
    logic [WIDTH-1:0]   w_nxt_lo;

    assign w_signed = op_is_signed(i_op);

    mdu_neg #(.WIDTH(WIDTH)) u_abs_a (
        .i_neg (w_signed & i_op1[WIDTH-1]),
        .i_a   (i_op1),
        .o_y   (w_abs_a)
    );

    mdu_neg #(.WIDTH(WIDTH)) u_abs_b (
        .i_neg (w_signed & i_op2[WIDTH-1]),
        .i_a   (i_op2),
        .o_y   (w_abs_b)
    );

    mdu_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_neg (r_sgn_diff),
        .i_a   ({r_acc_hi, r_acc_lo}),
        .o_y   (w_prod)
    );

    mdu_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .i_neg (r_sgn_diff),
        .i_a   (r_acc_lo),
        .o_y   (w_quo)
    );

    mdu_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .i_neg (r_sgn_a),
        .i_a   (r_acc_hi),
        .o_y   (w_rem)
    );

    // Multiply: add multiplicand on LSB, shift right. Divide: restoring
    // shift-left / trial-subtract, quotient bits enter at the LSB of acc_lo.
    assign w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
    assign w_rem_sh = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_opb});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_opb;

    always_comb begin
        w_nxt_hi = w_sum[WIDTH:1];
        w_nxt_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
        if (op_is_div(r_op)) begin
            w_nxt_hi = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
            w_nxt_lo = {r_acc_lo[WIDTH-2:0], w_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= MDU_MULTU;
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opb      <= '0;
            r_sgn_diff <= 1'b0;
            r_sgn_a    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_op       <= i_op;
                        r_acc_hi   <= '0;
                        r_acc_lo   <= w_abs_a;
                        r_opb      <= w_abs_b;
                        r_sgn_diff <= w_signed & (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
                        r_sgn_a    <= w_signed & i_op1[WIDTH-1];
                        r_cnt      <= CNT_W'(WIDTH - 1);
                        r_busy     <= 1'b1;
                        r_state    <= ST_CALC;
                    end else begin
                        if (i_wr_hi) r_hi <= i_wr_data;
                        if (i_wr_lo) r_lo <= i_wr_data;
                    end
                end
                ST_CALC: begin
                    r_acc_hi <= w_nxt_hi;
                    r_acc_lo <= w_nxt_lo;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    if (op_is_div(r_op)) begin
                        r_hi  <= w_rem;
                        r_lo  <= w_quo;
                        r_dbz <= (r_opb == '0);
                    end else begin
                        r_hi  <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo  <= w_prod[WIDTH-1:0];
                        r_dbz <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_32.sv
// ============================================================================
//  Module : tb_mdu_32
//  Scoreboard bench for mdu_32 with directed, hand-computed vectors.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mdu_32;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        i_wr_hi;
    logic        i_wr_lo;
    logic [31:0] i_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_div_by_zero;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    mdu_32 dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_op1         (i_op1),
        .i_op2         (i_op2),
        .i_wr_hi       (i_wr_hi),
        .i_wr_lo       (i_wr_lo),
        .i_wr_data     (i_wr_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_div_by_zero (o_div_by_zero),
        .o_hi          (o_hi),
        .o_lo          (o_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!rst && o_done) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(o_hi == e.hi, "result_hi", 64'(o_hi), 64'(e.hi));
                check(o_lo == e.lo, "result_lo", 64'(o_lo), 64'(e.lo));
                check(o_div_by_zero == e.dbz, "div_by_zero",
                      64'(o_div_by_zero), 64'(e.dbz));
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                          input bit interfere, input bit wr_at_start);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int n;
        int busy_cnt;
        exp_q.push_back('{hi: ehi, lo: elo, dbz: edbz});
        @(negedge clk);
        prev_hi = o_hi;
        prev_lo = o_lo;
        i_start = 1'b1;
        i_op    = op;
        i_op1   = a;
        i_op2   = b;
        if (wr_at_start) begin
            i_wr_lo   = 1'b1;
            i_wr_data = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        i_start = 1'b0;
        i_wr_lo = 1'b0;
        if (wr_at_start)
            check(o_lo == prev_lo, "start_wins_over_wr", 64'(o_lo), 64'(prev_lo));
        n = 0;
        busy_cnt = 0;
        while (!o_done && n < 100) begin
            if (o_busy) busy_cnt++;
            if (interfere && n == 12)
                check(o_hi == prev_hi, "wr_hi_while_busy", 64'(o_hi), 64'(prev_hi));
            if (interfere && n == 10) begin
                i_start   = 1'b1;
                i_op      = MDU_DIVU;
                i_op1     = 32'd100;
                i_op2     = 32'd3;
                i_wr_hi   = 1'b1;
                i_wr_data = 32'h0000_1234;
            end else begin
                i_start = 1'b0;
                i_wr_hi = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check(n == 33, "latency", 64'(n), 64'd33);
        check(busy_cnt == 33, "busy_cycles", 64'(busy_cnt), 64'd33);
        check(o_busy == 1'b0, "busy_after_done", 64'(o_busy), 64'd0);
        @(negedge clk);
        check(o_done == 1'b0, "done_one_cycle", 64'(o_done), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_op = MDU_MULTU;
        i_op1 = '0;
        i_op2 = '0;
        i_wr_hi = 1'b0;
        i_wr_lo = 1'b0;
        i_wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check(o_hi == 32'd0, "reset_hi", 64'(o_hi), 64'd0);
        check(o_lo == 32'd0, "reset_lo", 64'(o_lo), 64'd0);
        check(o_busy == 1'b0, "reset_busy", 64'(o_busy), 64'd0);
        check(o_done == 1'b0, "reset_done", 64'(o_done), 64'd0);
        check(o_div_by_zero == 1'b0, "reset_dbz", 64'(o_div_by_zero), 64'd0);

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0);
        run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
        run_op(MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 0, 0);
        run_op(MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 0, 0);
        run_op(MDU_DIVU,  32'd9,         32'd3,         32'd0,         32'd3,         1'b0, 0, 0);
        run_op(MDU_MULTU, 32'd6,         32'd7,         32'd0,         32'd42,        1'b0, 1, 0);

        // Direct HI/LO loads while idle
        @(negedge clk);
        i_wr_hi = 1'b1;
        i_wr_data = 32'h0000_1234;
        @(negedge clk);
        i_wr_hi = 1'b0;
        check(o_hi == 32'h0000_1234, "mthi_idle", 64'(o_hi), 64'h1234);
        i_wr_lo = 1'b1;
        i_wr_data = 32'h0000_ABCD;
        @(negedge clk);
        i_wr_lo = 1'b0;
        check(o_lo == 32'h0000_ABCD, "mtlo_idle", 64'(o_lo), 64'hABCD);
        check(o_hi == 32'h0000_1234, "mthi_kept", 64'(o_hi), 64'h1234);

        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 0, 1);
        run_op(MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 0, 0);
        run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 0, 0);
        run_op(MDU_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'd1,         1'b1, 0, 0);

        // Abort an in-flight multiply with reset
        @(negedge clk);
        i_start = 1'b1;
        i_op = MDU_MULTU;
        i_op1 = 32'h0001_0000;
        i_op2 = 32'h0001_0000;
        @(negedge clk);
        i_start = 1'b0;
        repeat (15) @(negedge clk);
        check(o_busy == 1'b1, "busy_before_abort", 64'(o_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check(o_hi == 32'd0, "abort_hi", 64'(o_hi), 64'd0);
        check(o_lo == 32'd0, "abort_lo", 64'(o_lo), 64'd0);
        check(o_busy == 1'b0, "abort_busy", 64'(o_busy), 64'd0);
        check(o_done == 1'b0, "abort_done", 64'(o_done), 64'd0);
        check(o_div_by_zero == 1'b0, "abort_dbz", 64'(o_div_by_zero), 64'd0);
        repeat (40) @(negedge clk);

        run_op(MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0, 0);

        repeat (3) @(negedge clk);
        check(exp_q.size() == 0, "results_pending", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_32.md
# mdu_32

Iterative multiply/divide unit for the execute stage, beside the 32-bit ALU. It takes the same register-file operands and computes MULT/MULTU/DIV/DIVU over 32 cycles into architectural HI/LO registers. The unit reports busy/done to the pipeline control so hazard logic can stall MFHI/MFLO until the result is ready. HI/LO can also be loaded directly (MTHI/MTLO).

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- op1  in  32  multiplicand / dividend (rs).
- op2  in  32  multiplier / divisor (rt).
- wr_hi  in  1  load HI from wr_data (MTHI).
- wr_lo  in  1  load LO from wr_data (MTLO).
- wr_data  in  32  data for wr_hi/wr_lo.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- div_by_zero  out  1  last completed operation was a divide with op2==0; held until next completion.
- hi  out  32  HI register (product[63:32] / remainder).
- lo  out  32  LO register (product[31:0] / quotient).

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 → latch op; latch |op1|,|op2| for signed ops, raw values for unsigned; latch result-sign flags; cnt=31; go to CALC.
  - wr_hi/wr_lo load hi/lo only in IDLE and only when start=0; start wins a simultaneous request.
  - wr_hi/wr_lo in CALC/FIX are ignored.
- CALC:
  - One shift-add (multiply) or one restoring shift-subtract (divide) step per cycle.
  - 64-bit accumulator {acc_hi, acc_lo}.
  - cnt decrements; cnt==0 → FIX.
- FIX:
  - Apply sign correction. MULT: negate the 64-bit product if the operand signs differ. DIV: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write hi/lo, set div_by_zero, assert done, return to IDLE.
- Divide by zero: no special path. Unsigned-magnitude result is quotient 0xFFFFFFFF and remainder |op1|, then sign-fixed as usual. div_by_zero=1.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- All arithmetic is mod 2^64 (mult) / 2^32 (div); no overflow flag.
- hi/lo hold their value between operations; outputs are straight register outputs.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE, cnt=0.
- start sampled at edge E0 → busy=1 after E0.
- CALC occupies edges E1..E32; FIX at edge E33 writes hi/lo.
- After E33: done=1 for exactly one cycle, busy=0.
- Latency start→done: 33 cycles.
- A new start may be sampled at E33+1 (same cycle done is high).
- start while busy=1 is ignored (not queued); the in-flight operation is unaffected.
- wr_hi/wr_lo take effect at the sampling edge; the new value is visible the next cycle.
- Reset at any edge (including mid-CALC or FIX) aborts the operation. All outputs return to reset values; done is not pulsed.

## Structure
- Package mdu_pkg:
  - op encodings MDU_MULTU/MULT/DIVU/DIV.
  - state enum (IDLE, CALC, FIX).
  - WIDTH and counter width (5).
- Sub-module mdu_neg: combinational conditional two's-complement negate, parameterized width. Instantiated for operand abs (32) and result fix (64/32).
- Single FSM plus datapath in mdu_32; no other hierarchy.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF → done at start+33, hi=0xFFFFFFFE, lo=0x00000001, busy high for 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV −7 / 2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU 100 / 7 → lo=14, hi=2.
- DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5, div_by_zero=1. A following DIVU 9/3 clears div_by_zero, giving lo=3, hi=0.
- Second start at start+10 with different operands → ignored; first result unchanged. wr_hi=1, wr_data=0x1234 while busy → ignored. Same wr in IDLE → hi=0x1234 next cycle.
- rst asserted at start+15 → next cycle hi=lo=0, busy=0, no done pulse. Fresh MULTU 3×4 then gives lo=12 at +33.
